// File: rtl/rns_mod_add_arbiter_if.sv
// Request/result bus between four requesters, the shared modular adder and its consumer.
// Transfer rule: a beat moves on the rising edge when its valid and ready are both high.
interface rns_mod_add_arbiter_if #(
    parameter int W = 8
);
    logic [3:0]     req_valid;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic [3:0]     req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;
    logic           res_err;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err
    );
endinterface

// File: rtl/rns_mod_add_arbiter.sv
// Four-way round-robin arbiter sharing one registered (a+b) mod MOD adder.
// Operands >= MOD flag res_err and force res_data to zero.
module rns_mod_add_arbiter #(
    parameter int MOD = 255,
    parameter int W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    rns_mod_add_arbiter_if.slave      bus,
    output logic [15:0]               op_count
);
    localparam logic [W:0] MOD_W = (W+1)'(MOD);

    logic [1:0]   r_last_grant;
    logic         r_res_valid;
    logic [W-1:0] r_res_data;
    logic [1:0]   r_res_id;
    logic         r_res_err;
    logic [15:0]  r_op_count;

    logic         w_can_accept;
    logic         w_found;
    logic [1:0]   w_cand;
    logic [1:0]   w_idx;
    logic [3:0]   w_grant;
    logic         w_xfer;
    logic         w_res_hs;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W:0]   w_sum;
    logic         w_err;
    logic [W-1:0] w_res;

    assign w_can_accept = !r_res_valid || bus.res_ready;
    assign w_res_hs     = r_res_valid && bus.res_ready;

    // Search starts just after the last granted requester, wrapping modulo 4.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_last_grant + 2'(k + 1);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (w_found && w_can_accept && !rst) begin
            w_grant[w_idx] = 1'b1;
        end
    end

    assign w_xfer = |w_grant;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_idx == 2'(i)) begin
                w_a = bus.req_a[i*W +: W];
                w_b = bus.req_b[i*W +: W];
            end
        end
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_err = ({1'b0, w_a} >= MOD_W) || ({1'b0, w_b} >= MOD_W);

    // Both operands in range means the sum is below 2*MOD, so one subtraction suffices.
    always_comb begin
        w_res = '0;
        if (w_err) begin
            w_res = '0;
        end else if (w_sum >= MOD_W) begin
            w_res = W'(w_sum - MOD_W);
        end else begin
            w_res = W'(w_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 2'd3;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_id     <= '0;
            r_res_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_xfer) begin
                r_last_grant <= w_idx;
                r_res_valid  <= 1'b1;
                r_res_data   <= w_res;
                r_res_id     <= w_idx;
                r_res_err    <= w_err;
            end else if (w_res_hs) begin
                r_res_valid  <= 1'b0;
            end
            if (w_res_hs) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;
    assign bus.res_err   = r_res_err;
    assign op_count      = r_op_count;
endmodule

// File: tb/tb_rns_mod_add_arbiter.sv
// Directed bench for rns_mod_add_arbiter: reset, modular sums, round-robin order,
// backpressure, reset mid-flight and op_count wrap.
module tb_rns_mod_add_arbiter;
    localparam int W   = 8;
    localparam int MOD = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    rns_mod_add_arbiter_if #(.W(W)) bus ();

    rns_mod_add_arbiter #(.MOD(MOD), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[idx*W +: W] = a;
        bus.req_b[idx*W +: W] = b;
    endtask

    // Called at a falling edge; leaves the bench at the falling edge after the result loads.
    task automatic single(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_data, input logic exp_err);
        bus.req_valid = 4'(1 << idx);
        set_op(idx, a, b);
        #1;
        chk("single_grant", 32'(bus.req_ready), 32'(1 << idx));
        @(negedge clk);
        chk("single_valid", 32'(bus.res_valid), 32'd1);
        chk("single_id",    32'(bus.res_id),    32'(idx));
        chk("single_data",  32'(bus.res_data),  32'(exp_data));
        chk("single_err",   32'(bus.res_err),   32'(exp_err));
    endtask

    initial begin
        int g;
        rst           = 1'b1;
        bus.req_valid = 4'h0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;

        // Reset values and grant suppression during reset
        @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        chk("rst_ready_zero", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data",  32'(bus.res_data),  32'd0);
        chk("rst_res_id",    32'(bus.res_id),    32'd0);
        chk("rst_res_err",   32'(bus.res_err),   32'd0);
        chk("rst_op_count",  32'(op_count),      32'd0);

        // First request after reset: 200+100 mod 255 = 45
        rst = 1'b0;
        single(0, 8'd200, 8'd100, 8'd45, 1'b0);

        // Boundary sums, back-to-back
        single(1, 8'd254, 8'd1,   8'd0,   1'b0);
        single(2, 8'd254, 8'd254, 8'd253, 1'b0);
        single(3, 8'd0,   8'd0,   8'd0,   1'b0);
        single(0, 8'd255, 8'd0,   8'd0,   1'b1);
        single(1, 8'd3,   8'd255, 8'd0,   1'b1);

        bus.req_valid = 4'h0;
        @(negedge clk);
        chk("drain_valid", 32'(bus.res_valid), 32'd0);
        chk("drain_count", 32'(op_count),      32'd6);

        // All four valid: last grant was 1, so order is 2,3,0,1,2,3,0,1; data = 10i+6
        for (int i = 0; i < 4; i++) set_op(i, 8'(10 * i + 1), 8'd5);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            g = (2 + k) % 4;
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << g));
            @(negedge clk);
            chk("rr_id",   32'(bus.res_id),   32'(g));
            chk("rr_data", 32'(bus.res_data), 32'(10 * g + 6));
        end
        chk("rr_count", 32'(op_count), 32'd13);

        // Backpressure: nothing granted, result held
        bus.res_ready = 1'b0;
        #1;
        chk("bp_ready_zero", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("bp_ready",  32'(bus.req_ready), 32'd0);
            chk("bp_valid",  32'(bus.res_valid), 32'd1);
            chk("bp_id",     32'(bus.res_id),    32'd1);
            chk("bp_data",   32'(bus.res_data),  32'd16);
            chk("bp_count",  32'(op_count),      32'd13);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("bp_release_id",    32'(bus.res_id),    32'd2);
        chk("bp_release_data",  32'(bus.res_data),  32'd26);
        chk("bp_release_count", 32'(op_count),      32'd14);

        // Reset while a result is pending and everyone requests
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("midrst_valid", 32'(bus.res_valid), 32'd0);
        chk("midrst_count", 32'(op_count),      32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_first_grant", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        chk("midrst_first_id",   32'(bus.res_id),   32'd0);
        chk("midrst_first_data", 32'(bus.res_data), 32'd6);

        // op_count wrap: drain to count 1, then 65534 more handshakes
        bus.req_valid = 4'h0;
        @(negedge clk);
        chk("wrap_start", 32'(op_count), 32'd1);
        bus.req_valid = 4'hF;
        repeat (65535) @(negedge clk);
        bus.req_valid = 4'h0;
        chk("wrap_max",       32'(op_count),      32'd65535);
        chk("wrap_max_valid", 32'(bus.res_valid), 32'd1);
        @(negedge clk);
        chk("wrap_zero",       32'(op_count),      32'd0);
        chk("wrap_zero_valid", 32'(bus.res_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rns_mod_add_arbiter.md
RNS_MOD_ADD_ARBITER -- requirements
Module: rns_mod_add_arbiter

Interface
REQ-001 Parameter: MOD, default 255, modulus of the shared adder; legal range 2..256.
REQ-002 Parameter: W, default 8, operand and result width; MOD SHALL be at most 2^W.
REQ-003 Port: clk  input  1  single clock; every register updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req_valid  input  4  per-requester request valid.
REQ-006 Port: req_a  input  4*W  packed operand A; requester i occupies bits [i*W +: W].
REQ-007 Port: req_b  input  4*W  packed operand B, same packing as req_a.
REQ-008 Port: req_ready  output  4  one-hot grant and accept strobe, combinational.
REQ-009 Port: res_valid  output  1  result register holds a valid result.
REQ-010 Port: res_ready  input  1  downstream accepts the result.
REQ-011 Port: res_data  output  W  registered (a+b) mod MOD.
REQ-012 Port: res_id  output  2  index of the requester that owns res_data.
REQ-013 Port: res_err  output  1  operand out of range (>= MOD) on this result.
REQ-014 Port: op_count  output  16  count of completed result handshakes.

Function
REQ-015 A request transfers when req_valid[i] and req_ready[i] are both high in the same cycle; a result transfers when res_valid and res_ready are both high.
REQ-016 can_accept = !res_valid | res_ready; when can_accept is low, req_ready SHALL be all zero.
REQ-017 When can_accept is high, req_ready SHALL be one-hot on the first valid requester in round-robin order starting at (last_grant+1) mod 4, or zero if no requester is valid.
REQ-018 req_ready SHALL depend only on req_valid, last_grant, res_valid and res_ready; req_valid is not permitted to depend on req_ready.
REQ-019 last_grant SHALL update to the granted index only on a transfer cycle; otherwise it holds.
REQ-020 On a transfer, the next edge loads res_valid=1, res_id=granted index, res_data and res_err; latency is 1 cycle from accept to res_valid.
REQ-021 Arithmetic: s = a+b computed at W+1 bits; res_data = s-MOD if s >= MOD, else s.
REQ-022 If a >= MOD or b >= MOD, res_err=1 and res_data=0; otherwise res_err=0.
REQ-023 If there is a result handshake and no transfer in the same cycle, res_valid SHALL clear on the next edge.
REQ-024 A result handshake together with a new transfer (back-to-back) SHALL replace the result register with no bubble; sustained throughput is 1 per cycle.
REQ-025 While res_valid=1 and res_ready=0, res_data, res_id and res_err SHALL hold stable.
REQ-026 op_count SHALL increment by 1 on each result handshake and wrap from 65535 to 0.
REQ-027 A requester that holds req_valid high without a grant SHALL be granted within 4 transfer cycles; no requester starves.

Reset
REQ-028 When rst=1 at an edge: res_valid=0, res_data=0, res_id=0, res_err=0, op_count=0, last_grant=3 (requester 0 has highest priority first).
REQ-029 While rst=1, req_ready SHALL be forced to zero; an in-flight result is discarded and no transfer is counted.
REQ-030 The first grant after rst deasserts SHALL follow REQ-017 with last_grant=3.

Verification
REQ-031 After reset, requester 0 drives a=200, b=100 with MOD=255 and res_ready=1 -> req_ready=0001 that cycle; next cycle res_valid=1, res_data=45, res_id=0, res_err=0.
REQ-032 Boundary sums with MOD=255: a=254,b=1 -> 0; a=254,b=254 -> 253; a=0,b=0 -> 0; a=255,b=0 -> res_err=1, res_data=0.
REQ-033 All four requesters valid continuously with res_ready=1 -> grants cycle 0,1,2,3,0,...; res_id follows one cycle later; op_count=8 after 8 results.
REQ-034 Hold res_ready=0 for 3 cycles with all requesters valid -> req_ready=0000 and res_data/res_id stable throughout; on release, the next grant goes to last_grant+1.
REQ-035 Assert rst while res_valid=1 and requesters are valid -> next cycle res_valid=0, op_count=0; the first grant after release goes to requester 0.
REQ-036 Preload op_count to 65535 via 65535 handshakes, then complete one more handshake -> op_count=0.
